// File: rtl/ahb_arbiter_rr_if.sv
// Bus-side signals of the AHB arbiter: request/lock/split lines in, grant and
// address-phase ownership out. The arbiter uses the slave modport.
interface ahb_arbiter_rr_if #(
    parameter int NUM_MASTERS = 4
);
    localparam int MASTER_W = $clog2(NUM_MASTERS);

    logic [NUM_MASTERS-1:0] hbusreq;
    logic [NUM_MASTERS-1:0] hlock;
    logic [NUM_MASTERS-1:0] hsplit;
    logic                   hready;
    logic [1:0]             hresp;
    logic [1:0]             htrans;
    logic [NUM_MASTERS-1:0] hgrant;
    logic [MASTER_W-1:0]    hmaster;
    logic                   hmastlock;

    modport slave (
        input  hbusreq, hlock, hsplit, hready, hresp, htrans,
        output hgrant, hmaster, hmastlock
    );

    modport master (
        output hbusreq, hlock, hsplit, hready, hresp, htrans,
        input  hgrant, hmaster, hmastlock
    );
endinterface

// File: rtl/ahb_arbiter_rr.sv
// Registered AHB bus arbiter: round-robin or fixed priority, locked hold,
// SPLIT masking with per-master release, hready-qualified grant handover.
module ahb_arbiter_rr #(
    parameter int NUM_MASTERS    = 4,
    parameter int MASTER_W       = $clog2(NUM_MASTERS),
    parameter int DEFAULT_MASTER = 0,
    parameter bit RR_MODE        = 1'b1
) (
    input  logic                   hclk,
    input  logic                   hreset,
    ahb_arbiter_rr_if.slave        bus,
    output logic [NUM_MASTERS-1:0] dbg_split_mask,
    output logic [MASTER_W-1:0]    dbg_rr_ptr
);
    localparam logic [1:0] HRESP_SPLIT = 2'b11;
    localparam logic [1:0] HTRANS_IDLE = 2'b00;

    logic [NUM_MASTERS-1:0] hgrant_q, hgrant_d;
    logic [MASTER_W-1:0]    hmaster_q, hmaster_d;
    logic                   hmastlock_q, hmastlock_d;
    logic [NUM_MASTERS-1:0] split_mask_q, split_mask_d;
    logic [MASTER_W-1:0]    rr_ptr_q, rr_ptr_d;

    logic [MASTER_W-1:0]    owner;
    logic [NUM_MASTERS-1:0] elig;
    logic [NUM_MASTERS-1:0] split_set;
    logic                   locked_hold;
    logic [MASTER_W-1:0]    low_idx;
    logic [MASTER_W-1:0]    rr_idx;
    logic [MASTER_W-1:0]    scan_idx;
    logic                   rr_found;
    logic [MASTER_W-1:0]    sel;

    // Handshake: hready high on an edge is the only point where ownership
    // moves; with hready low every grant-side register holds its value.
    always_comb begin
        owner = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (hgrant_q[i]) owner = MASTER_W'(i);
        end

        elig        = bus.hbusreq & ~split_mask_q;
        locked_hold = bus.hlock[owner] & bus.hbusreq[owner] & ~split_mask_q[owner];

        low_idx = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (elig[i]) low_idx = MASTER_W'(i);
        end

        rr_idx   = '0;
        rr_found = 1'b0;
        scan_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            scan_idx = MASTER_W'((int'(rr_ptr_q) + i) % NUM_MASTERS);
            if (!rr_found && elig[scan_idx]) begin
                rr_idx   = scan_idx;
                rr_found = 1'b1;
            end
        end

        // A bit being released on the same edge it is split stays clear.
        split_set = '0;
        if (bus.hresp == HRESP_SPLIT && !bus.hready) split_set[hmaster_q] = 1'b1;
        split_mask_d = (split_mask_q | split_set) & ~bus.hsplit;

        hgrant_d    = hgrant_q;
        hmaster_d   = hmaster_q;
        hmastlock_d = hmastlock_q;
        rr_ptr_d    = rr_ptr_q;
        sel         = owner;

        if (bus.hready) begin
            if (locked_hold) begin
                sel = owner;
            end else if (elig == '0) begin
                sel = MASTER_W'(DEFAULT_MASTER);
            end else begin
                sel      = RR_MODE ? rr_idx : low_idx;
                rr_ptr_d = MASTER_W'((int'(sel) + 1) % NUM_MASTERS);
            end
            hgrant_d      = '0;
            hgrant_d[sel] = 1'b1;
            hmaster_d     = owner;
            hmastlock_d   = bus.hlock[owner] & (bus.htrans != HTRANS_IDLE);
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            hgrant_q     <= NUM_MASTERS'(1) << DEFAULT_MASTER;
            hmaster_q    <= MASTER_W'(DEFAULT_MASTER);
            hmastlock_q  <= 1'b0;
            split_mask_q <= '0;
            rr_ptr_q     <= '0;
        end else begin
            hgrant_q     <= hgrant_d;
            hmaster_q    <= hmaster_d;
            hmastlock_q  <= hmastlock_d;
            split_mask_q <= split_mask_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    assign bus.hgrant     = hgrant_q;
    assign bus.hmaster    = hmaster_q;
    assign bus.hmastlock  = hmastlock_q;
    assign dbg_split_mask = split_mask_q;
    assign dbg_rr_ptr     = rr_ptr_q;
endmodule

// File: tb/tb_ahb_arbiter_rr.sv
// Bench for ahb_arbiter_rr: a round-robin and a fixed-priority instance share
// the same stimulus and are both compared every cycle against a rule model.
module tb_ahb_arbiter_rr;
    localparam int N   = 4;
    localparam int DEF = 0;

    logic       hclk = 1'b0;
    logic       hreset;
    logic [3:0] hbusreq, hlock, hsplit;
    logic       hready;
    logic [1:0] hresp, htrans;

    logic [3:0] dbg_mask_rr, dbg_mask_fx;
    logic [1:0] dbg_ptr_rr, dbg_ptr_fx;

    ahb_arbiter_rr_if #(.NUM_MASTERS(N)) bus_rr ();
    ahb_arbiter_rr_if #(.NUM_MASTERS(N)) bus_fx ();

    assign bus_rr.hbusreq = hbusreq;
    assign bus_rr.hlock   = hlock;
    assign bus_rr.hsplit  = hsplit;
    assign bus_rr.hready  = hready;
    assign bus_rr.hresp   = hresp;
    assign bus_rr.htrans  = htrans;
    assign bus_fx.hbusreq = hbusreq;
    assign bus_fx.hlock   = hlock;
    assign bus_fx.hsplit  = hsplit;
    assign bus_fx.hready  = hready;
    assign bus_fx.hresp   = hresp;
    assign bus_fx.htrans  = htrans;

    ahb_arbiter_rr #(.NUM_MASTERS(N), .DEFAULT_MASTER(DEF), .RR_MODE(1'b1)) u_rr (
        .hclk(hclk), .hreset(hreset), .bus(bus_rr),
        .dbg_split_mask(dbg_mask_rr), .dbg_rr_ptr(dbg_ptr_rr)
    );
    ahb_arbiter_rr #(.NUM_MASTERS(N), .DEFAULT_MASTER(DEF), .RR_MODE(1'b0)) u_fx (
        .hclk(hclk), .hreset(hreset), .bus(bus_fx),
        .dbg_split_mask(dbg_mask_fx), .dbg_rr_ptr(dbg_ptr_fx)
    );

    // ---------------- clock ----------------
    always #5 hclk = ~hclk;

    // ---------------- model state (index 0 = round-robin, 1 = fixed) ----------------
    int       n_chk  = 0;
    int       n_pass = 0;
    int       m_grant[2];
    int       m_master[2];
    int       m_ptr[2];
    bit       m_lock[2];
    bit [3:0] m_mask[2];
    logic [3:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Applies one clock edge of the arbitration rules to both model copies.
    task automatic model_step();
        int       owner;
        int       ng;
        int       c;
        bit       rr;
        bit [3:0] elig;
        for (int k = 0; k < 2; k++) begin
            rr = (k == 0);
            if (hreset) begin
                m_grant[k] = DEF; m_master[k] = DEF; m_lock[k] = 1'b0;
                m_mask[k] = 4'b0; m_ptr[k] = 0;
            end else begin
                owner = m_grant[k];
                elig  = hbusreq & ~m_mask[k];
                ng    = owner;
                if (hready) begin
                    if (hlock[owner] && hbusreq[owner] && !m_mask[k][owner]) begin
                        ng = owner;
                    end else if (elig == 4'b0) begin
                        ng = DEF;
                    end else begin
                        ng = -1;
                        for (int j = 0; j < N; j++) begin
                            c = rr ? (m_ptr[k] + j) % N : j;
                            if (ng < 0 && elig[c]) ng = c;
                        end
                        m_ptr[k] = (ng + 1) % N;
                    end
                end
                if (hresp == 2'b11 && !hready) m_mask[k][m_master[k]] = 1'b1;
                m_mask[k] = m_mask[k] & ~hsplit;
                if (hready) begin
                    m_master[k] = owner;
                    m_lock[k]   = hlock[owner] && (htrans != 2'b00);
                    m_grant[k]  = ng;
                end
            end
        end
        exp_q.push_back(4'b0001 << m_grant[0]);
    endtask

    task automatic compare();
        logic [3:0] eg;
        eg = exp_q.pop_front();
        chk("rr_grant",    bus_rr.hgrant,    eg);
        chk("rr_master",   bus_rr.hmaster,   m_master[0]);
        chk("rr_mastlock", bus_rr.hmastlock, m_lock[0]);
        chk("rr_mask",     dbg_mask_rr,      m_mask[0]);
        chk("rr_ptr",      dbg_ptr_rr,       m_ptr[0]);
        chk("fx_grant",    bus_fx.hgrant,    4'b0001 << m_grant[1]);
        chk("fx_master",   bus_fx.hmaster,   m_master[1]);
        chk("fx_mastlock", bus_fx.hmastlock, m_lock[1]);
        chk("fx_mask",     dbg_mask_fx,      m_mask[1]);
    endtask

    // Inputs change only after a check, i.e. 1 time unit past the edge.
    task automatic step();
        @(posedge hclk);
        model_step();
        #1;
        compare();
    endtask

    initial begin
        hreset = 1'b1; hbusreq = '0; hlock = '0; hsplit = '0;
        hready = 1'b1; hresp = 2'b00; htrans = 2'b00;
        step(); step();
        chk("reset_grant",    bus_rr.hgrant,    4'b0001);
        chk("reset_master",   bus_rr.hmaster,   0);
        chk("reset_mastlock", bus_rr.hmastlock, 0);
        hreset = 1'b0;

        // T1: all requesting, round-robin rotation
        hbusreq = 4'b1111; htrans = 2'b10;
        step(); chk("t1_g0", bus_rr.hgrant, 4'b0001);
        step(); chk("t1_g1", bus_rr.hgrant, 4'b0010);
        step(); chk("t1_g2", bus_rr.hgrant, 4'b0100); chk("t1_m1", bus_rr.hmaster, 1);
        step(); chk("t1_g3", bus_rr.hgrant, 4'b1000);
        step(); chk("t1_g4", bus_rr.hgrant, 4'b0001); chk("t1_m3", bus_rr.hmaster, 3);

        // T2: fixed priority
        hbusreq = 4'b1110;
        step(); chk("t2_fx_a", bus_fx.hgrant, 4'b0010);
        step(); chk("t2_fx_b", bus_fx.hgrant, 4'b0010);
        hbusreq = 4'b1100;
        step(); chk("t2_fx_drop", bus_fx.hgrant, 4'b0100);

        // T3: locked hold on master 2
        hbusreq = 4'b0100;
        step(); chk("t3_g2", bus_rr.hgrant, 4'b0100);
        hbusreq = 4'b1111; hlock = 4'b0100;
        step(); step();
        chk("t3_hold", bus_rr.hgrant, 4'b0100);
        chk("t3_mastlock", bus_rr.hmastlock, 1);
        hlock = 4'b0000;
        step(); chk("t3_release", bus_rr.hgrant, 4'b1000);

        // T4: SPLIT mask and unsplit release of master 1
        hbusreq = 4'b0010;
        step(); step(); chk("t4_m1", bus_rr.hmaster, 1);
        hresp = 2'b11; hready = 1'b0;
        step(); chk("t4_mask", dbg_mask_rr, 4'b0010);
        hready = 1'b1;
        step(); chk("t4_default", bus_rr.hgrant, 4'b0001);
        hresp = 2'b00; hbusreq = 4'b1111;
        step(); chk("t4_s2", bus_rr.hgrant, 4'b0100);
        step(); chk("t4_s3", bus_rr.hgrant, 4'b1000);
        step(); chk("t4_s0", bus_rr.hgrant, 4'b0001);
        step(); chk("t4_skip1", bus_rr.hgrant, 4'b0100);
        hsplit = 4'b0010;
        step(); chk("t4_rel_g", bus_rr.hgrant, 4'b1000); chk("t4_rel_mask", dbg_mask_rr, 4'b0000);
        hsplit = 4'b0000;
        step(); chk("t4_s0b", bus_rr.hgrant, 4'b0001);
        step(); chk("t4_regrant1", bus_rr.hgrant, 4'b0010);

        // T5: hready low holds everything
        hready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            hbusreq = 4'($urandom_range(0, 15));
            step();
            chk("t5_hold_g", bus_rr.hgrant, 4'b0010);
            chk("t5_hold_m", bus_rr.hmaster, 0);
        end
        hready = 1'b1; hbusreq = 4'b1000;
        step(); chk("t5_resolve_g", bus_rr.hgrant, 4'b1000); chk("t5_resolve_m", bus_rr.hmaster, 1);

        // T6: reset mid-burst with masters 1 and 2 split
        hresp = 2'b11; hready = 1'b0;
        step();
        hresp = 2'b00; hready = 1'b1; hbusreq = 4'b0100;
        step(); step(); chk("t6_m2", bus_rr.hmaster, 2);
        hresp = 2'b11; hready = 1'b0;
        step(); chk("t6_mask", dbg_mask_rr, 4'b0110);
        hreset = 1'b1; hresp = 2'b00; hlock = 4'b1111;
        step();
        chk("t6_grant", bus_rr.hgrant, 4'b0001);
        chk("t6_master", bus_rr.hmaster, 0);
        chk("t6_mastlock", bus_rr.hmastlock, 0);
        chk("t6_mask0", dbg_mask_rr, 4'b0000);
        chk("t6_ptr0", dbg_ptr_rr, 0);
        hreset = 1'b0; hlock = 4'b0000; hready = 1'b1;

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            hreset  = ($urandom_range(0, 199) == 0);
            hbusreq = 4'($urandom_range(0, 15));
            hlock   = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            hsplit  = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            hready  = ($urandom_range(0, 3) != 0);
            hresp   = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'b00;
            htrans  = 2'($urandom_range(0, 3));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
